exc_vector_ctrl: RTL and testbench

EXC_VECTOR_CTRL -- requirements
Module: exc_vector_ctrl

---
 rtl/exc_vector_ctrl_if.sv | 41 ++++
 rtl/exc_vector_ctrl.sv | 144 ++++++++++++++
 tb/tb_exc_vector_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_vector_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | exc_vector_ctrl_if : source, configuration and CPU handshake bundle      |
// | for the exception vector controller.                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface exc_vector_ctrl_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_EXC = 16
);
    localparam int ADDR_SIZE = $clog2(NUM_EXC);

    logic [NUM_EXC-1:0]   excpt_en;
    logic                 mask_we;
    logic [NUM_EXC-1:0]   mask_wdata;
    logic                 vec_we;
    logic [ADDR_SIZE-1:0] vec_idx;
    logic [WIDTH-1:0]     vec_wdata;
    logic                 irq_ack;
    logic                 eret;
    logic                 irq_req;
    logic [ADDR_SIZE-1:0] irq_id;
    logic [WIDTH-1:0]     excpt_addr;
    logic                 busy;
    logic [NUM_EXC-1:0]   pending;

    modport master (
        output excpt_en, mask_we, mask_wdata, vec_we, vec_idx, vec_wdata,
               irq_ack, eret,
        input  irq_req, irq_id, excpt_addr, busy, pending
    );

    modport slave (
        input  excpt_en, mask_we, mask_wdata, vec_we, vec_idx, vec_wdata,
               irq_ack, eret,
        output irq_req, irq_id, excpt_addr, busy, pending
    );
endinterface

`default_nettype wire

// File: rtl/exc_vector_ctrl.sv
// +--------------------------------------------------------------------------+
// | exc_vector_ctrl : edge-triggered, maskable, fixed-priority exception     |
// | controller with a writable handler-address vector table.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module exc_vector_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NUM_EXC = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    exc_vector_ctrl_if.slave   bus
);
    localparam int ADDR_SIZE = $clog2(NUM_EXC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e                              state_q;
    logic [NUM_EXC-1:0]                  excpt_q;
    logic [NUM_EXC-1:0]                  pending_q;
    logic [NUM_EXC-1:0]                  pending_d;
    logic [NUM_EXC-1:0]                  mask_q;
    logic                                irq_req_q;
    logic                                busy_q;
    logic [ADDR_SIZE-1:0]                irq_id_q;
    logic [WIDTH-1:0]                    addr_q;

    logic [NUM_EXC-1:0]                  rise;
    logic [NUM_EXC-1:0]                  active;
    logic [NUM_EXC-1:0]                  ack_clr;
    logic                                ack_hit;
    logic                                sel_valid;
    logic [ADDR_SIZE-1:0]                sel_idx;
    logic [NUM_EXC-1:0][WIDTH-1:0]       vec_rd;

    assign rise    = bus.excpt_en & ~excpt_q;
    assign active  = pending_q & mask_q;
    assign ack_hit = (state_q == ST_REQ) && bus.irq_ack;

    always_comb begin
        ack_clr = '0;
        if (ack_hit) begin
            ack_clr[irq_id_q] = 1'b1;
        end
    end

    // A new edge on the bit being acknowledged wins over the clear.
    assign pending_d = (pending_q & ~ack_clr) | rise;

    // Lowest set index wins; scanning downward leaves it as the final value.
    always_comb begin
        sel_valid = |active;
        sel_idx   = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel_idx = ADDR_SIZE'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excpt_q   <= '0;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            excpt_q   <= bus.excpt_en;
            pending_q <= pending_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_EXC; gi++) begin : g_vec
        logic [WIDTH-1:0] entry_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_q <= WIDTH'(gi * 4);
            end else if (bus.vec_we && (bus.vec_idx == ADDR_SIZE'(gi))) begin
                entry_q <= bus.vec_wdata;
            end
        end

        assign vec_rd[gi] = entry_q;
    end

    // The selected address is captured from the pre-write table contents,
    // so a same-cycle write to that entry only affects later selections.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b0;
            irq_id_q  <= '0;
            addr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state_q   <= ST_REQ;
                        irq_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        irq_id_q  <= sel_idx;
                        addr_q    <= vec_rd[sel_idx];
                    end
                end
                ST_REQ: begin
                    if (bus.irq_ack) begin
                        state_q   <= ST_SERVICE;
                        irq_req_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eret) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.excpt_addr = addr_q;
    assign bus.busy       = busy_q;
    assign bus.pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_vector_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_exc_vector_ctrl : directed scenarios plus randomized traffic checked  |
// | against a rule-level reference model of the exception controller.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_exc_vector_ctrl;
    localparam int W = 16;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    exc_vector_ctrl_if #(.WIDTH(W), .NUM_EXC(N)) bus ();
    exc_vector_ctrl #(.WIDTH(W), .NUM_EXC(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state: what the CPU should see, in plain terms.
    logic [N-1:0] m_prev, m_pend, m_mask;
    logic [W-1:0] m_vec [N];
    bit           m_req, m_svc;
    logic [3:0]   m_id;
    logic [W-1:0] m_addr;

    function void model_reset();
        m_prev = '0; m_pend = '0; m_mask = '1;
        for (int i = 0; i < N; i++) m_vec[i] = W'(i * 4);
        m_req = 0; m_svc = 0; m_id = '0; m_addr = '0;
    endfunction

    function void model_step();
        logic [N-1:0] nxt;
        logic [N-1:0] avail;
        bit found;
        if (!rst) begin
            model_reset();
            return;
        end
        nxt = m_pend;
        if (m_req && bus.irq_ack) nxt[m_id] = 1'b0;
        nxt = nxt | (bus.excpt_en & ~m_prev);
        avail = m_pend & m_mask;
        if (!m_req && !m_svc) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && avail[i]) begin
                    found = 1; m_req = 1; m_id = 4'(i); m_addr = m_vec[i];
                end
            end
        end else if (m_req) begin
            if (bus.irq_ack) begin m_req = 0; m_svc = 1; end
        end else if (bus.eret) begin
            m_svc = 0;
        end
        if (bus.mask_we) m_mask = bus.mask_wdata;
        if (bus.vec_we) m_vec[bus.vec_idx] = bus.vec_wdata;
        m_prev = bus.excpt_en;
        m_pend = nxt;
    endfunction

    function logic [37:0] model_out();
        return {m_req, m_req | m_svc, m_id, m_addr, m_pend};
    endfunction

    task tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task clear_inputs();
        bus.excpt_en = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.vec_we = 1'b0; bus.vec_idx = '0; bus.vec_wdata = '0;
        bus.irq_ack = 1'b0; bus.eret = 1'b0;
    endtask

    task test_reset();
        clear_inputs();
        rst = 1'b0;
        model_reset();
        tick(); tick();
        total++;
        if ({bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending} !== 38'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending});
        end
        rst = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.irq_req !== 1'b0) begin
            bad++; $display("FAIL reset_release busy=%b req=%b want 0 0", bus.busy, bus.irq_req);
        end
    endtask

    task test_basic();
        bus.excpt_en[3] = 1'b1;
        tick();
        total++;
        if (bus.irq_req !== 1'b0 || bus.pending[3] !== 1'b1) begin
            bad++; $display("FAIL basic_latency1 req=%b pend3=%b want 0 1", bus.irq_req, bus.pending[3]);
        end
        bus.excpt_en[3] = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 4'd3 || bus.excpt_addr !== 16'h000C) begin
            bad++; $display("FAIL basic_req req=%b id=%0d addr=%h want 1 3 000c",
                            bus.irq_req, bus.irq_id, bus.excpt_addr);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.irq_req !== 1'b0 || bus.pending[3] !== 1'b0) begin
            bad++; $display("FAIL basic_service busy=%b req=%b pend3=%b want 1 0 0",
                            bus.busy, bus.irq_req, bus.pending[3]);
        end
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL basic_eret busy=%b want 0", bus.busy);
        end
    endtask

    task test_priority();
        bus.excpt_en = 16'h0024;
        tick();
        bus.excpt_en = '0;
        tick();
        total++;
        if (bus.irq_id !== 4'd2 || bus.excpt_addr !== 16'h0008) begin
            bad++; $display("FAIL prio_first id=%0d addr=%h want 2 0008", bus.irq_id, bus.excpt_addr);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 4'd5 || bus.excpt_addr !== 16'h0014) begin
            bad++; $display("FAIL prio_second req=%b id=%0d addr=%h want 1 5 0014",
                            bus.irq_req, bus.irq_id, bus.excpt_addr);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    endtask

    task test_mask();
        bus.mask_we = 1'b1; bus.mask_wdata = 16'hFFFE;
        tick();
        bus.mask_we = 1'b0;
        bus.excpt_en[0] = 1'b1; tick();
        bus.excpt_en[0] = 1'b0; tick(); tick();
        total++;
        if (bus.irq_req !== 1'b0 || bus.busy !== 1'b0 || bus.pending[0] !== 1'b1) begin
            bad++; $display("FAIL mask_hold req=%b busy=%b pend0=%b want 0 0 1",
                            bus.irq_req, bus.busy, bus.pending[0]);
        end
        bus.mask_we = 1'b1; bus.mask_wdata = 16'hFFFF;
        tick();
        bus.mask_we = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 4'd0) begin
            bad++; $display("FAIL mask_release req=%b id=%0d want 1 0", bus.irq_req, bus.irq_id);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    endtask

    task test_vector();
        bus.vec_we = 1'b1; bus.vec_idx = 4'd7; bus.vec_wdata = 16'hBEEF;
        tick();
        bus.vec_we = 1'b0;
        bus.excpt_en[7] = 1'b1; tick();
        bus.excpt_en[7] = 1'b0; tick();
        total++;
        if (bus.excpt_addr !== 16'hBEEF) begin
            bad++; $display("FAIL vec_written addr=%h want beef", bus.excpt_addr);
        end
        bus.vec_we = 1'b1; bus.vec_wdata = 16'h1234;
        tick();
        bus.vec_we = 1'b0;
        total++;
        if (bus.excpt_addr !== 16'hBEEF || bus.irq_req !== 1'b1) begin
            bad++; $display("FAIL vec_latched addr=%h req=%b want beef 1", bus.excpt_addr, bus.irq_req);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        bus.excpt_en[7] = 1'b1; tick();
        bus.excpt_en[7] = 1'b0;
        bus.vec_we = 1'b1; bus.vec_wdata = 16'hCAFE;
        tick();
        bus.vec_we = 1'b0;
        total++;
        if (bus.excpt_addr !== 16'h1234) begin
            bad++; $display("FAIL vec_same_cycle addr=%h want 1234", bus.excpt_addr);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    endtask

    task test_hold();
        bus.excpt_en[1] = 1'b1;
        tick(); tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        tick(); tick(); tick();
        total++;
        if (bus.pending[1] !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL hold_single pend1=%b busy=%b want 0 1", bus.pending[1], bus.busy);
        end
        bus.excpt_en[1] = 1'b0; tick();
        bus.excpt_en[1] = 1'b1; tick();
        total++;
        if (bus.pending[1] !== 1'b1 || bus.irq_req !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL hold_in_service pend1=%b req=%b busy=%b want 1 0 1",
                            bus.pending[1], bus.irq_req, bus.busy);
        end
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 4'd1) begin
            bad++; $display("FAIL hold_reissue req=%b id=%0d want 1 1", bus.irq_req, bus.irq_id);
        end
        total++;
        if ({bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending} !== model_out()) begin
            bad++; $display("FAIL hold_model got=%h want=%h",
                            {bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending}, model_out());
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        bus.excpt_en = '0; tick();
    endtask

    task test_reset_mid();
        bus.mask_we = 1'b1; bus.mask_wdata = 16'h00FF; tick(); bus.mask_we = 1'b0;
        bus.excpt_en[4] = 1'b1; tick();
        bus.excpt_en[4] = 1'b0; tick();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.excpt_en[6] = 1'b1; tick(); bus.excpt_en[6] = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.irq_req !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 16'h0000) begin
            bad++; $display("FAIL rstmid_abort req=%b busy=%b pend=%h want 0 0 0000",
                            bus.irq_req, bus.busy, bus.pending);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.excpt_en = 16'h1080;
        tick();
        bus.excpt_en = '0;
        tick();
        total++;
        if (bus.irq_id !== 4'd7 || bus.excpt_addr !== 16'h001C) begin
            bad++; $display("FAIL rstmid_vec id=%0d addr=%h want 7 001c", bus.irq_id, bus.excpt_addr);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        tick();
        total++;
        if (bus.irq_req !== 1'b1 || bus.irq_id !== 4'd12 || bus.excpt_addr !== 16'h0030) begin
            bad++; $display("FAIL rstmid_mask req=%b id=%0d addr=%h want 1 12 0030",
                            bus.irq_req, bus.irq_id, bus.excpt_addr);
        end
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    endtask

    task test_random();
        for (int c = 0; c < 600; c++) begin
            bus.excpt_en   = bus.excpt_en ^ N'($urandom & $urandom & $urandom);
            bus.irq_ack    = ($urandom_range(0, 2) == 0);
            bus.eret       = ($urandom_range(0, 3) == 0);
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = N'($urandom);
            bus.vec_we     = ($urandom_range(0, 7) == 0);
            bus.vec_idx    = 4'($urandom_range(0, N - 1));
            bus.vec_wdata  = W'($urandom);
            tick();
            total++;
            if ({bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending} !== model_out()) begin
                bad++; $display("FAIL random_cycle%0d got=%h want=%h", c,
                                {bus.irq_req, bus.busy, bus.irq_id, bus.excpt_addr, bus.pending},
                                model_out());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_vector();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
